// File: rtl/mm_trg_run_ctrl.sv
// Run controller for the minimum-trigger datapath: calibrates the ADC baseline,
// then enables the trigger and drains open trigger windows on stop.
module mm_trg_run_ctrl #(
  parameter int unsigned ADC_RESOLUTION_WIDTH = 12,
  parameter int unsigned S_AXIS_TDATA_WIDTH   = 128,
  parameter int unsigned CALIB_LOG2_BEATS     = 10,
  parameter int unsigned TIME_STAMP_WIDTH     = 16,
  parameter int unsigned DRAIN_TIMEOUT        = 256
) (
  input  logic                                   AXIS_ACLK,
  input  logic                                   AXIS_ARESETN,
  input  logic                                   RUN_START,
  input  logic                                   RUN_STOP,
  input  logic [S_AXIS_TDATA_WIDTH-1:0]          S_AXIS_TDATA,
  input  logic                                   S_AXIS_TVALID,
  input  logic                                   TRIGGERED_FLAG,
  output logic [1:0]                             EXEC_STATE,
  output logic signed [ADC_RESOLUTION_WIDTH-1:0] BASELINE,
  output logic [TIME_STAMP_WIDTH-1:0]            CURRENT_TIME,
  output logic                                   CALIB_DONE,
  output logic                                   BUSY,
  output logic                                   DRAIN_ERR
);

  localparam int unsigned ADC_W    = ADC_RESOLUTION_WIDTH;
  localparam int unsigned SPT      = S_AXIS_TDATA_WIDTH / 16;
  localparam int unsigned LOG2_SPT = (SPT > 1) ? $clog2(SPT) : 0;
  localparam int unsigned SUM_W    = ADC_W + LOG2_SPT;
  localparam int unsigned ACC_W    = SUM_W + CALIB_LOG2_BEATS;
  localparam int unsigned SHIFT    = LOG2_SPT + CALIB_LOG2_BEATS;
  localparam int unsigned CNT_W    = CALIB_LOG2_BEATS + 1;
  localparam int unsigned BEATS    = 1 << CALIB_LOG2_BEATS;
  localparam int unsigned DRAIN_W  = $clog2(DRAIN_TIMEOUT + 1);
  localparam int unsigned TS_W     = TIME_STAMP_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALIB = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                    state_r, state_nxt;
  logic signed [ACC_W-1:0]   acc_r, acc_nxt;
  logic [CNT_W-1:0]          cnt_r, cnt_nxt;
  logic [DRAIN_W-1:0]        drain_cnt_r, drain_cnt_nxt;
  logic signed [ADC_W-1:0]   baseline_nxt;
  logic [TS_W-1:0]           time_nxt;
  logic                      calib_done_nxt, drain_err_nxt, busy_nxt;
  logic [1:0]                exec_nxt;
  logic signed [SUM_W-1:0]   beat_sum;
  logic                      unused_tdata;

  // Upper bits of each 16-bit lane carry no sample data.
  assign unused_tdata = ^S_AXIS_TDATA;

  // Sign-extended sum of all lanes in the current beat.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < int'(SPT); i++) begin
      beat_sum = beat_sum + SUM_W'($signed(S_AXIS_TDATA[16*i +: ADC_W]));
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt      = state_r;
    acc_nxt        = acc_r;
    cnt_nxt        = cnt_r;
    drain_cnt_nxt  = drain_cnt_r;
    baseline_nxt   = BASELINE;
    time_nxt       = CURRENT_TIME;
    calib_done_nxt = CALIB_DONE;
    drain_err_nxt  = DRAIN_ERR;

    case (state_r)
      IDLE: begin
        if (RUN_START && !RUN_STOP) begin
          state_nxt      = CALIB;
          acc_nxt        = '0;
          cnt_nxt        = '0;
          calib_done_nxt = 1'b0;
          drain_err_nxt  = 1'b0;
        end
      end
      CALIB: begin
        // Abort wins over both accumulation and the baseline load.
        if (RUN_STOP) begin
          state_nxt = IDLE;
        end else if (cnt_r == CNT_W'(BEATS)) begin
          state_nxt      = RUN;
          baseline_nxt   = ADC_W'(acc_r >>> SHIFT);
          calib_done_nxt = 1'b1;
          time_nxt       = '0;
        end else if (S_AXIS_TVALID) begin
          acc_nxt = acc_r + ACC_W'(beat_sum);
          cnt_nxt = cnt_r + CNT_W'(1);
        end
      end
      RUN: begin
        time_nxt = CURRENT_TIME + TS_W'(1);
        if (RUN_STOP) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = '0;
        end
      end
      DRAIN: begin
        time_nxt = CURRENT_TIME + TS_W'(1);
        if (!TRIGGERED_FLAG) begin
          state_nxt = IDLE;
        end else if (drain_cnt_r == DRAIN_W'(DRAIN_TIMEOUT - 1)) begin
          state_nxt     = IDLE;
          drain_err_nxt = 1'b1;
        end else begin
          drain_cnt_nxt = drain_cnt_r + DRAIN_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    exec_nxt = ((state_nxt == RUN) || (state_nxt == DRAIN)) ? 2'b11 : 2'b00;
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_r      <= IDLE;
      acc_r        <= '0;
      cnt_r        <= '0;
      drain_cnt_r  <= '0;
      EXEC_STATE   <= 2'b00;
      BASELINE     <= '0;
      CURRENT_TIME <= '0;
      CALIB_DONE   <= 1'b0;
      BUSY         <= 1'b0;
      DRAIN_ERR    <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      acc_r        <= acc_nxt;
      cnt_r        <= cnt_nxt;
      drain_cnt_r  <= drain_cnt_nxt;
      EXEC_STATE   <= exec_nxt;
      BASELINE     <= baseline_nxt;
      CURRENT_TIME <= time_nxt;
      CALIB_DONE   <= calib_done_nxt;
      BUSY         <= busy_nxt;
      DRAIN_ERR    <= drain_err_nxt;
    end
  end

endmodule

// File: tb/tb_mm_trg_run_ctrl.sv
// Directed bench for mm_trg_run_ctrl: two instances share stimulus, one with a short
// drain timeout and 4-bit timestamp, one with a long timeout and 16-bit timestamp.
module tb_mm_trg_run_ctrl;

  logic         clk, rst_n;
  logic         run_start, run_stop, tvalid, flag;
  logic [127:0] tdata;

  logic [1:0]  a_exec, b_exec;
  logic [11:0] a_base, b_base;
  logic [3:0]  a_time;
  logic [15:0] b_time;
  logic        a_done, b_done, a_busy, b_busy, a_err, b_err;

  int vectors = 0;
  int miscompares = 0;

  mm_trg_run_ctrl #(
    .ADC_RESOLUTION_WIDTH(12), .S_AXIS_TDATA_WIDTH(128), .CALIB_LOG2_BEATS(2),
    .TIME_STAMP_WIDTH(4), .DRAIN_TIMEOUT(8)
  ) u_a (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .RUN_START(run_start), .RUN_STOP(run_stop),
    .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid), .TRIGGERED_FLAG(flag),
    .EXEC_STATE(a_exec), .BASELINE(a_base), .CURRENT_TIME(a_time),
    .CALIB_DONE(a_done), .BUSY(a_busy), .DRAIN_ERR(a_err)
  );

  mm_trg_run_ctrl #(
    .ADC_RESOLUTION_WIDTH(12), .S_AXIS_TDATA_WIDTH(128), .CALIB_LOG2_BEATS(2),
    .TIME_STAMP_WIDTH(16), .DRAIN_TIMEOUT(256)
  ) u_b (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .RUN_START(run_start), .RUN_STOP(run_stop),
    .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid), .TRIGGERED_FLAG(flag),
    .EXEC_STATE(b_exec), .BASELINE(b_base), .CURRENT_TIME(b_time),
    .CALIB_DONE(b_done), .BUSY(b_busy), .DRAIN_ERR(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] lanes(input logic signed [15:0] ev, input logic signed [15:0] od);
    logic [127:0] d;
    for (int i = 0; i < 8; i++) d[16*i +: 16] = (i % 2 == 0) ? ev : od;
    return d;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Calibrate with all lanes = 100 and return one cycle after RUN entry (time = 0).
  task automatic start_run();
    run_start = 1'b1; tvalid = 1'b1; tdata = lanes(16'sd100, 16'sd100); flag = 1'b0;
    tick();
    run_start = 1'b0;
    repeat (5) tick();
  endtask

  task automatic end_run();
    flag = 1'b0; run_stop = 1'b1;
    tick();
    run_stop = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run_start = 1'b0; run_stop = 1'b0; tvalid = 1'b0; flag = 1'b0; tdata = '0;
    #12;
    vectors++;
    if ({a_exec, a_base, a_time, a_done, a_busy, a_err} !== '0) begin
      miscompares++; $display("FAIL reset_a: got %h required 0", {a_exec, a_base, a_time, a_done, a_busy, a_err});
    end
    vectors++;
    if ({b_exec, b_base, b_time, b_done, b_busy, b_err} !== '0) begin
      miscompares++; $display("FAIL reset_b: got %h required 0", {b_exec, b_base, b_time, b_done, b_busy, b_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_calib_basic();
    run_start = 1'b1; tvalid = 1'b1; tdata = lanes(16'sd100, 16'sd100);
    tick();
    run_start = 1'b0;
    vectors++;
    if (b_busy !== 1'b1 || b_exec !== 2'b00) begin
      miscompares++; $display("FAIL calib_entry: busy=%b exec=%b required busy=1 exec=00", b_busy, b_exec);
    end
    repeat (4) tick();
    vectors++;
    if (b_exec !== 2'b00 || b_done !== 1'b0) begin
      miscompares++; $display("FAIL calib_4beats: exec=%b done=%b required 00/0", b_exec, b_done);
    end
    tick();
    vectors++;
    if (b_exec !== 2'b11 || b_base !== 12'd100 || b_done !== 1'b1 || b_time !== 16'd0) begin
      miscompares++;
      $display("FAIL run_entry: exec=%b base=%0d done=%b time=%0d required 11/100/1/0", b_exec, b_base, b_done, b_time);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if (b_time !== 16'(k)) begin
        miscompares++; $display("FAIL run_time: got %0d required %0d", b_time, k);
      end
    end
    // RUN_START while running must be ignored.
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    vectors++;
    if (b_exec !== 2'b11 || b_done !== 1'b1) begin
      miscompares++; $display("FAIL start_in_run: exec=%b done=%b required 11/1", b_exec, b_done);
    end
    end_run();
    vectors++;
    if (b_busy !== 1'b0 || b_exec !== 2'b00) begin
      miscompares++; $display("FAIL stop_to_idle: busy=%b exec=%b required 0/00", b_busy, b_exec);
    end
  endtask

  task automatic test_tvalid_gaps();
    run_start = 1'b1; tvalid = 1'b0;
    tick();
    run_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tvalid = (k % 2 == 0);
      tdata  = tvalid ? lanes(-16'sd3, 16'sd2) : lanes(16'sd2047, 16'sd2047);
      tick();
    end
    tvalid = 1'b0;
    vectors++;
    if (b_exec !== 2'b00) begin
      miscompares++; $display("FAIL gaps_still_calib: exec=%b required 00", b_exec);
    end
    tick();
    vectors++;
    if (b_exec !== 2'b11 || b_base !== 12'hFFF || a_base !== 12'hFFF) begin
      miscompares++; $display("FAIL gaps_baseline: exec=%b base=%h/%h required 11 fff/fff", b_exec, b_base, a_base);
    end
    end_run();
  endtask

  task automatic test_abort();
    // Establish BASELINE = 55.
    run_start = 1'b1; tvalid = 1'b1; tdata = lanes(16'sd55, 16'sd55);
    tick();
    run_start = 1'b0;
    repeat (5) tick();
    end_run();
    vectors++;
    if (b_base !== 12'd55 || b_done !== 1'b1) begin
      miscompares++; $display("FAIL base55: base=%0d done=%b required 55/1", b_base, b_done);
    end
    // Stop on the 2nd beat.
    tdata = lanes(16'sd500, 16'sd500);
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    tick();
    run_stop = 1'b1;
    tick();
    run_stop = 1'b0;
    repeat (4) tick();
    vectors++;
    if (b_busy !== 1'b0 || b_exec !== 2'b00 || b_base !== 12'd55 || b_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_beat2: busy=%b exec=%b base=%0d done=%b required 0/00/55/0", b_busy, b_exec, b_base, b_done);
    end
    // Stop coincides with the last beat.
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    repeat (3) tick();
    run_stop = 1'b1;
    tick();
    run_stop = 1'b0;
    repeat (3) tick();
    vectors++;
    if (b_busy !== 1'b0 || b_exec !== 2'b00 || b_base !== 12'd55 || b_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_last: busy=%b exec=%b base=%0d done=%b required 0/00/55/0", b_busy, b_exec, b_base, b_done);
    end
    // START and STOP together in IDLE: no-op.
    run_start = 1'b1; run_stop = 1'b1;
    tick();
    run_start = 1'b0; run_stop = 1'b0;
    vectors++;
    if (b_busy !== 1'b0 || a_busy !== 1'b0) begin
      miscompares++; $display("FAIL start_stop_idle: busy=%b/%b required 0/0", a_busy, b_busy);
    end
  endtask

  task automatic test_drain();
    start_run();
    flag = 1'b1; run_stop = 1'b1;
    tick();
    run_stop = 1'b0;
    vectors++;
    if (b_exec !== 2'b11 || b_busy !== 1'b1) begin
      miscompares++; $display("FAIL drain_entry: exec=%b busy=%b required 11/1", b_exec, b_busy);
    end
    repeat (9) tick();
    vectors++;
    if (b_exec !== 2'b11 || a_err !== 1'b1 || a_busy !== 1'b0) begin
      miscompares++; $display("FAIL drain_hold: b_exec=%b a_err=%b a_busy=%b required 11/1/0", b_exec, a_err, a_busy);
    end
    flag = 1'b0;
    tick();
    vectors++;
    if (b_busy !== 1'b0 || b_exec !== 2'b00 || b_err !== 1'b0 || b_time !== 16'd11) begin
      miscompares++;
      $display("FAIL drain_exit: busy=%b exec=%b err=%b time=%0d required 0/00/0/11", b_busy, b_exec, b_err, b_time);
    end
  endtask

  task automatic test_drain_timeout();
    start_run();
    flag = 1'b1; run_stop = 1'b1;
    tick();
    run_stop = 1'b0;
    repeat (7) tick();
    vectors++;
    if (a_exec !== 2'b11 || a_err !== 1'b0) begin
      miscompares++; $display("FAIL timeout_7: exec=%b err=%b required 11/0", a_exec, a_err);
    end
    tick();
    vectors++;
    if (a_busy !== 1'b0 || a_exec !== 2'b00 || a_err !== 1'b1) begin
      miscompares++; $display("FAIL timeout_8: busy=%b exec=%b err=%b required 0/00/1", a_busy, a_exec, a_err);
    end
    flag = 1'b0;
    tick();
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    vectors++;
    if (a_err !== 1'b0 || a_busy !== 1'b1) begin
      miscompares++; $display("FAIL err_clear: err=%b busy=%b required 0/1", a_err, a_busy);
    end
    run_stop = 1'b1;
    tick();
    run_stop = 1'b0;
    tick();
  endtask

  task automatic test_wrap_and_reset();
    start_run();
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 15 || k == 16 || k == 20) begin
        vectors++;
        if (a_time !== 4'(k % 16)) begin
          miscompares++; $display("FAIL time_wrap_%0d: got %0d required %0d", k, a_time, k % 16);
        end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({a_exec, a_base, a_time, a_done, a_busy, a_err} !== '0 || b_exec !== 2'b00 || b_time !== 16'd0) begin
      miscompares++;
      $display("FAIL midrun_reset: a=%h b_exec=%b b_time=%0d required 0", {a_exec, a_base, a_time, a_done, a_busy, a_err}, b_exec, b_time);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_calib_basic();
    test_tvalid_gaps();
    test_abort();
    test_drain();
    test_drain_timeout();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
